modulo_varredura_matriz: RTL and testbench
==========================================

Name: modulo_varredura_matriz

Overview:
- Row-scan driver for the 7x5 LED matrix. Sits directly downstream of the input-negation/remap stage.
- Consumes its 35-bit active-low, row-major pattern N_m_at. Row r occupies N_m_at[5r+4:5r], r = 0..6.
- Time-multiplexes the pattern onto 7 row enables and 5 shared column lines.
- Adds anti-ghosting blanking between rows and a tear-free shadow register latched once per frame.

Parameters:
- DWELL, 1000, clock cycles each row is lit. Legal range ≥1.
- BLANK, 16, clock cycles all rows and columns are off before each row. Legal range ≥0; 0 skips blanking.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- en  input  1  scan enable; level-sensitive.
- N_m_at  input  35  active-low pattern from the negation stage; row r = bits [5r+4:5r].
- linhas  output  7  one-hot active-high row enable; bit r lights row r.
- colunas  output  5  active-low column drive for the lit row.
- row_idx  output  3  index of the row currently in BLANK/SHOW, 0..6.
- frame_done  output  1  one-cycle pulse marking the last cycle of a frame.

Behaviour:
- Reset (async, asserted): state=IDLE; linhas=0; colunas=5'b11111; row_idx=0; frame_done=0; shadow=all ones; dwell counter=0. Applies immediately, including mid-frame. Deassertion takes effect at the next rising edge.
- All outputs are registered; no combinational path from any input to any output.
- States:
  - IDLE: outputs off (linhas=0, colunas=11111). en=1 → LOAD.
  - LOAD: exactly 1 cycle; shadow<=N_m_at; row_idx<=0; outputs off. Next state is BLANK, or SHOW if BLANK=0.
  - BLANK: BLANK cycles; linhas=0, colunas=11111; row_idx holds current row. Then SHOW.
  - SHOW: DWELL cycles; linhas=(1<<row_idx); colunas=shadow[5*row_idx+4 : 5*row_idx].
    - At the end of SHOW with row_idx<6: row_idx+1 → BLANK (or SHOW if BLANK=0).
    - At the end of SHOW with row_idx=6: → LOAD if en=1, else IDLE.
- Row order is 0,1,...,6. row_idx never exceeds 6 and wraps only through LOAD.
- Frame length = 1 + 7*(BLANK+DWELL) cycles.
- frame_done is high exactly during the final SHOW cycle of row 6; low otherwise.
- N_m_at changes mid-frame are ignored; they take effect at the next LOAD.
- en deasserted in any non-IDLE state: next cycle → IDLE with outputs off and the counter cleared. No frame_done is emitted for an aborted frame.
- en reasserted while in IDLE: a full new frame starts with LOAD, re-latching N_m_at.
- Simultaneous en fall and row-6 final SHOW cycle: frame_done still pulses; next state is IDLE.
- Counter width: $clog2 of the larger of DWELL and BLANK, minimum 1 bit. Counter counts 0..N-1 per phase and resets on every state change.
- Never more than one bit of linhas is high. During BLANK, LOAD and IDLE, colunas=11111.

Test Plan:
- Reset: assert reset mid-SHOW of row 3 → same cycle linhas=0, colunas=11111, frame_done=0, row_idx=0. After release with en=0, the block stays IDLE.
- Full frame, DWELL=4, BLANK=1, N_m_at=35'h0_0000_0000 (all on), en=1 →
  - LOAD 1 cycle.
  - Then per row: 1 cycle all-off, then 4 cycles linhas=1<<r, colunas=00000.
  - frame_done pulses once at cycle 36 of the frame; the next LOAD follows immediately.
- Pattern mapping: N_m_at with only row 2 = 5'b01010, all other bits 1 → colunas=01010 only while linhas=7'b0000100; 11111 in all other rows.
- Tear-free: change N_m_at during row 1 SHOW → rows 1..6 still show the old pattern; the new pattern appears from the next frame's row 0.
- BLANK=0, DWELL=1 → linhas walks 0000001..1000000 on consecutive cycles with no off cycles; frame length 8 cycles.
- Abort: drop en during row 4 SHOW → next cycle linhas=0, colunas=11111, no frame_done. Re-raise en → LOAD, then row 0.

Source files
------------

// File: rtl/modulo_varredura_matriz.sv
`default_nettype none
// ============================================================================
// Module      : modulo_varredura_matriz
// Description : Row-scan driver for a 7x5 active-low LED matrix with
//               inter-row blanking and a per-frame shadow pattern register.
// Revision    : 1.0 - initial release
// ============================================================================
module modulo_varredura_matriz #(
    parameter int DWELL = 1000,
    parameter int BLANK = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [34:0] N_m_at,
    output logic [6:0]  linhas,
    output logic [4:0]  colunas,
    output logic [2:0]  row_idx,
    output logic        frame_done
);

    localparam int c_MAX   = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int c_CNT_W = (c_MAX > 1) ? $clog2(c_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [2:0]         c_LAST_ROW   = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_BLANK = 2'd2,
        S_SHOW  = 2'd3
    } state_t;

    localparam state_t c_ROW_ENTRY = (BLANK > 0) ? S_BLANK : S_SHOW;

    state_t               r_state, w_state;
    logic [c_CNT_W-1:0]   r_cnt,   w_cnt;
    logic [2:0]           r_row,   w_row;
    logic [34:0]          r_shadow;
    logic [34:0]          w_src;
    logic [5:0]           w_base;
    logic [6:0]           r_linhas,  w_linhas;
    logic [4:0]           r_colunas, w_colunas;
    logic                 r_frame_done, w_frame_done;

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt + c_CNT_W'(1);
        w_row   = r_row;
        case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                if (en) w_state = S_LOAD;
            end
            S_LOAD: begin
                w_cnt   = '0;
                w_state = c_ROW_ENTRY;
            end
            S_BLANK: begin
                if (r_cnt == c_BLANK_LAST) begin
                    w_cnt   = '0;
                    w_state = S_SHOW;
                end
            end
            S_SHOW: begin
                if (r_cnt == c_DWELL_LAST) begin
                    w_cnt = '0;
                    if (r_row == c_LAST_ROW) begin
                        w_state = S_LOAD;
                    end else begin
                        w_row   = r_row + 3'd1;
                        w_state = c_ROW_ENTRY;
                    end
                end
            end
            default: begin
                w_cnt   = '0;
                w_state = S_IDLE;
            end
        endcase

        // Losing enable anywhere in a frame abandons it outright.
        if (r_state != S_IDLE && !en) begin
            w_state = S_IDLE;
            w_cnt   = '0;
        end
        if (w_state == S_IDLE || w_state == S_LOAD) w_row = '0;
    end

    // Outputs are decoded from the next state and registered, so they line up
    // with the state register; the LOAD cycle forwards the pattern being latched.
    always_comb begin
        w_src        = (r_state == S_LOAD) ? N_m_at : r_shadow;
        w_base       = {3'b000, w_row} * 6'd5;
        w_linhas     = '0;
        w_colunas    = 5'b11111;
        w_frame_done = 1'b0;
        if (w_state == S_SHOW) begin
            w_linhas     = 7'b0000001 << w_row;
            w_colunas    = w_src[w_base +: 5];
            w_frame_done = (w_row == c_LAST_ROW) && (w_cnt == c_DWELL_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_row        <= '0;
            r_shadow     <= '1;
            r_linhas     <= '0;
            r_colunas    <= 5'b11111;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_row        <= w_row;
            r_linhas     <= w_linhas;
            r_colunas    <= w_colunas;
            r_frame_done <= w_frame_done;
            if (r_state == S_LOAD) r_shadow <= N_m_at;
        end
    end

    assign linhas     = r_linhas;
    assign colunas    = r_colunas;
    assign row_idx    = r_row;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_modulo_varredura_matriz.sv
`default_nettype none
// ============================================================================
// Module      : tb_modulo_varredura_matriz
// Description : Directed self-checking bench for the LED matrix row scanner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modulo_varredura_matriz;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_a, en_b;
    logic [34:0] pat_a, pat_b;
    logic [6:0]  linhas_a, linhas_b;
    logic [4:0]  colunas_a, colunas_b;
    logic [2:0]  row_a, row_b;
    logic        fd_a, fd_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    modulo_varredura_matriz #(.DWELL(4), .BLANK(1)) u_dut_a (
        .clk(clk), .reset(reset), .en(en_a), .N_m_at(pat_a),
        .linhas(linhas_a), .colunas(colunas_a), .row_idx(row_a), .frame_done(fd_a)
    );

    modulo_varredura_matriz #(.DWELL(1), .BLANK(0)) u_dut_b (
        .clk(clk), .reset(reset), .en(en_b), .N_m_at(pat_b),
        .linhas(linhas_b), .colunas(colunas_b), .row_idx(row_b), .frame_done(fd_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_off_a(input string tag);
        chk({tag, " linhas"},  35'(linhas_a),  35'h0);
        chk({tag, " colunas"}, 35'(colunas_a), 35'h1f);
        chk({tag, " fd"},      35'(fd_a),      35'h0);
    endtask

    initial begin
        logic [34:0] p1, p2;
        int          fd_count;

        reset = 1'b1;
        en_a  = 1'b0;
        en_b  = 1'b0;
        pat_a = '1;
        pat_b = '1;
        tick();
        chk_off_a("reset");
        chk("reset row_idx", 35'(row_a), 35'h0);

        reset = 1'b0;
        repeat (3) tick();
        chk_off_a("idle");

        // Full frame, every LED on
        pat_a = '0;
        en_a  = 1'b1;
        tick();
        chk_off_a("full load");
        for (int r = 0; r < 7; r++) begin
            tick();
            chk_off_a("full blank");
            chk("full blank row", 35'(row_a), 35'(r));
            for (int k = 0; k < 4; k++) begin
                tick();
                chk("full linhas",  35'(linhas_a),  35'(7'b1 << r));
                chk("full colunas", 35'(colunas_a), 35'h0);
                chk("full row",     35'(row_a),     35'(r));
                chk("full fd",      35'(fd_a),      35'((r == 6 && k == 3) ? 1 : 0));
            end
        end
        tick();
        chk_off_a("next load");

        // Abort during LOAD, then mapping and tear-free frame
        en_a = 1'b0;
        tick();
        chk_off_a("abort load");
        p1 = '1;
        p1[14:10] = 5'b01010;
        p2 = '0;
        pat_a = p1;
        en_a  = 1'b1;
        tick();
        chk_off_a("map load");
        for (int r = 0; r < 7; r++) begin
            tick();
            chk_off_a("map blank");
            for (int k = 0; k < 4; k++) begin
                tick();
                chk("map linhas",  35'(linhas_a),  35'(7'b1 << r));
                chk("map colunas", 35'(colunas_a), 35'((r == 2) ? 5'b01010 : 5'b11111));
                if (r == 1 && k == 0) pat_a = p2;
            end
        end
        tick();
        chk_off_a("tear load");
        tick();
        tick();
        chk("tear row0 linhas",  35'(linhas_a),  35'h1);
        chk("tear row0 colunas", 35'(colunas_a), 35'h0);

        // Abort during row 4 SHOW
        repeat (20) tick();
        chk("abort pre linhas", 35'(linhas_a), 35'(7'b0010000));
        chk("abort pre row",    35'(row_a),    35'h4);
        en_a = 1'b0;
        tick();
        chk_off_a("abort");
        fd_count = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (fd_a) fd_count++;
        end
        chk("abort fd count", 35'(fd_count), 35'h0);
        chk_off_a("abort idle");
        en_a = 1'b1;
        tick();
        chk_off_a("restart load");
        tick();
        chk_off_a("restart blank");
        tick();
        chk("restart linhas",  35'(linhas_a),  35'h1);
        chk("restart colunas", 35'(colunas_a), 35'h0);

        // No blanking, single-cycle dwell
        for (int r = 0; r < 7; r++) pat_b[5*r +: 5] = 5'(r + 1);
        en_b = 1'b1;
        tick();
        chk("b load linhas", 35'(linhas_b), 35'h0);
        chk("b load fd",     35'(fd_b),     35'h0);
        for (int r = 0; r < 7; r++) begin
            tick();
            chk("b linhas",  35'(linhas_b),  35'(7'b1 << r));
            chk("b colunas", 35'(colunas_b), 35'(r + 1));
            chk("b fd",      35'(fd_b),      35'((r == 6) ? 1 : 0));
        end
        tick();
        chk("b reload linhas",  35'(linhas_b),  35'h0);
        chk("b reload colunas", 35'(colunas_b), 35'h1f);
        tick();
        chk("b wrap linhas", 35'(linhas_b), 35'h1);

        // Asynchronous reset during row 3 SHOW
        en_a = 1'b0;
        tick();
        en_a = 1'b1;
        tick();
        repeat (17) tick();
        chk("pre reset linhas", 35'(linhas_a), 35'(7'b0001000));
        #2;
        reset = 1'b1;
        #1;
        chk_off_a("async reset");
        chk("async reset row", 35'(row_a), 35'h0);
        en_a = 1'b0;
        en_b = 1'b0;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk_off_a("post reset idle");
        chk("post reset row", 35'(row_a), 35'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
